alu_serial_ctrl: RTL

- Bit-serial initiator for the team's existing 1-bit ALU slice (instantiated alongside, not inside this block).
- Accepts a full-width operation, drives the slice one bit per cycle LSB-first, and chains carry, equality and set between cycles through its own registers.
- Reassembles result, overflow and carry-out, then signals completion.
- Sits in the area-reduced datapath option as a drop-in for the parallel ALU, using a start/done handshake.

---
 rtl/alu_serial_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl
//   Bit-serial initiator for an external 1-bit ALU slice. It accepts a
//   full-width operation on start_i and drives the slice one bit per cycle,
//   LSB first. Carry, equality and set are chained between cycles through
//   local registers. It then reassembles result, overflow and carry-out and
//   pulses done_o.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   start_i                      begin operation (sampled only in IDLE)
//   src1_i, src2_i [WIDTH]       operands, captured on accept
//   alu_ctrl_i [4]               {A_invert, B_invert, operation[1:0]}
//   bonus_op_i [3]               compare select
//   busy_o, done_o               handshake status / one-cycle completion pulse
//   result_o, overflow_o, cout_o assembled outputs, held until next completion
//   s_*_o                        slice drive
//   s_*_i                        slice returns
//
// Optional build macro ALU_SERIAL_ZERO_EN adds zero_o (result == 0).

module alu_serial_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       alu_ctrl_i,
    input  logic [2:0]       bonus_op_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o,
    output logic             cout_o,
    output logic             s_src1_o,
    output logic             s_src2_o,
    output logic             s_less_o,
    output logic             s_equal_o,
    output logic             s_in_equal_o,
    output logic             s_A_invert_o,
    output logic             s_B_invert_o,
    output logic             s_cin_o,
    output logic [1:0]       s_operation_o,
    output logic [2:0]       s_bonus_op_o,
    input  logic             s_result_i,
    input  logic             s_cout_i,
    input  logic             s_set_i,
    input  logic             s_set_equal_i,
    input  logic             s_overflow_i
`ifdef ALU_SERIAL_ZERO_EN
    ,
    output logic             zero_o
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [2:0]         bonus_q, bonus_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               eq_q, eq_d;
    logic               set_q, set_d;
    logic               ov_q, ov_d;
    logic               cout_q, cout_d;
`ifdef ALU_SERIAL_ZERO_EN
    logic               nz_q, nz_d;
    logic               zero_q, zero_d;
`endif

    logic               arith;
    logic               last_bit;
    logic [WIDTH-1:0]   res_shift;

    // The set value is taken from the slice sum on the last bit, so the
    // dedicated set return is not needed.
    logic unused_set;
    assign unused_set = s_set_i;

    assign arith     = (ctrl_q == 4'b0010) || (ctrl_q == 4'b0110);
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    assign res_shift = {s_result_i, res_sr_q[WIDTH-1:1]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            result_q <= '0;
            ctrl_q   <= '0;
            bonus_q  <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            eq_q     <= 1'b0;
            set_q    <= 1'b0;
            ov_q     <= 1'b0;
            cout_q   <= 1'b0;
`ifdef ALU_SERIAL_ZERO_EN
            nz_q     <= 1'b0;
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            result_q <= result_d;
            ctrl_q   <= ctrl_d;
            bonus_q  <= bonus_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            eq_q     <= eq_d;
            set_q    <= set_d;
            ov_q     <= ov_d;
            cout_q   <= cout_d;
`ifdef ALU_SERIAL_ZERO_EN
            nz_q     <= nz_d;
            zero_q   <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        a_sr_d        = a_sr_q;
        b_sr_d        = b_sr_q;
        res_sr_d      = res_sr_q;
        result_d      = result_q;
        ctrl_d        = ctrl_q;
        bonus_d       = bonus_q;
        cnt_d         = cnt_q;
        carry_d       = carry_q;
        eq_d          = eq_q;
        set_d         = set_q;
        ov_d          = ov_q;
        cout_d        = cout_q;
`ifdef ALU_SERIAL_ZERO_EN
        nz_d          = nz_q;
        zero_d        = zero_q;
`endif
        s_src1_o      = 1'b0;
        s_src2_o      = 1'b0;
        s_less_o      = 1'b0;
        s_equal_o     = 1'b0;
        s_in_equal_o  = 1'b0;
        s_A_invert_o  = 1'b0;
        s_B_invert_o  = 1'b0;
        s_cin_o       = 1'b0;
        s_operation_o = 2'b00;
        s_bonus_op_o  = 3'b000;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_sr_d  = src1_i;
                    b_sr_d  = src2_i;
                    ctrl_d  = alu_ctrl_i;
                    bonus_d = bonus_op_i;
                    cnt_d   = '0;
                    carry_d = alu_ctrl_i[2];
                    eq_d    = 1'b1;
`ifdef ALU_SERIAL_ZERO_EN
                    nz_d    = 1'b0;
`endif
                    state_d = RUN;
                end
            end

            RUN: begin
                s_src1_o      = a_sr_q[0];
                s_src2_o      = b_sr_q[0];
                s_cin_o       = carry_q;
                s_in_equal_o  = eq_q;
                s_A_invert_o  = ctrl_q[3];
                s_B_invert_o  = ctrl_q[2];
                // Compare runs the subtract chain here; the select happens in CMP.
                s_operation_o = (ctrl_q[1:0] == 2'b11) ? 2'b10 : ctrl_q[1:0];

                carry_d  = s_cout_i;
                eq_d     = s_set_equal_i;
                res_sr_d = res_shift;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
`ifdef ALU_SERIAL_ZERO_EN
                nz_d     = nz_q | s_result_i;
`endif
                if (last_bit) begin
                    set_d = s_result_i;
                    if (ctrl_q[1:0] == 2'b11) begin
                        state_d = CMP;
                    end else begin
                        state_d  = DONE;
                        result_d = res_shift;
                        ov_d     = arith & s_overflow_i;
                        cout_d   = arith & s_cout_i;
`ifdef ALU_SERIAL_ZERO_EN
                        zero_d   = ~(nz_q | s_result_i);
`endif
                    end
                end
            end

            CMP: begin
                s_operation_o = 2'b11;
                s_bonus_op_o  = bonus_q;
                s_less_o      = set_q;
                s_equal_o     = eq_q;

                res_sr_d = {{(WIDTH-1){1'b0}}, s_result_i};
                result_d = {{(WIDTH-1){1'b0}}, s_result_i};
                ov_d     = 1'b0;
                cout_d   = 1'b0;
`ifdef ALU_SERIAL_ZERO_EN
                zero_d   = ~s_result_i;
`endif
                state_d  = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = (state_q == RUN) || (state_q == CMP);
    assign done_o     = (state_q == DONE);
    assign result_o   = result_q;
    assign overflow_o = ov_q;
    assign cout_o     = cout_q;
`ifdef ALU_SERIAL_ZERO_EN
    assign zero_o     = zero_q;
`endif

endmodule
